reorder_buffer: RTL

- Dual-issue, in-order-commit reorder buffer directly downstream of the register-rename stage.
- Accepts up to two renamed instructions per cycle, each carrying its new physical destination and the previous mapping of its architectural destination.
- Records out-of-order completions from execute.
- Retires up to two instructions per cycle in program order, returning each retiring instruction's old physical destination to rename as freereg_1/freereg_2.

---
 rtl/reorder_buffer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// Dual-issue reorder buffer. It allocates renamed instruction pairs, records
// out-of-order completion, and retires up to two entries per cycle in program order.
module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int PREG_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              alloc_valid_1,
  input  logic              alloc_valid_2,
  input  logic              regwrite_1,
  input  logic              regwrite_2,
  input  logic [PREG_W-1:0] rdout_1,
  input  logic [PREG_W-1:0] rdout_2,
  input  logic [PREG_W-1:0] olddest_1,
  input  logic [PREG_W-1:0] olddest_2,
  output logic              alloc_ready,
  output logic [IDX_W-1:0]  rob_idx_1,
  output logic [IDX_W-1:0]  rob_idx_2,
  input  logic              cmpl_valid_a,
  input  logic              cmpl_valid_b,
  input  logic [IDX_W-1:0]  cmpl_idx_a,
  input  logic [IDX_W-1:0]  cmpl_idx_b,
  output logic              freereg_valid_1,
  output logic              freereg_valid_2,
  output logic [PREG_W-1:0] freereg_1,
  output logic [PREG_W-1:0] freereg_2,
  output logic [1:0]        retire_cnt,
  output logic              rob_empty
);
  localparam logic [IDX_W:0]   PTR_ZERO = {(IDX_W+1){1'b0}};
  localparam logic [IDX_W:0]   PTR_ONE  = {{IDX_W{1'b0}}, 1'b1};
  localparam logic [IDX_W:0]   PTR_TWO  = {{(IDX_W-1){1'b0}}, 2'b10};
  localparam logic [IDX_W+1:0] DEPTH_P  = (IDX_W+2)'(DEPTH);
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [PREG_W-1:0] PREG_ZERO = {PREG_W{1'b0}};

  logic [DEPTH-1:0]  valid_q, done_q, regwr_q;
  logic [PREG_W-1:0] rd_q  [DEPTH];
  logic [PREG_W-1:0] old_q [DEPTH];
  logic [IDX_W:0]    head_q, tail_q, head_d, tail_d, count_s;
  logic [IDX_W+1:0]  free_s;
  logic [IDX_W-1:0]  hidx_1_s, hidx_2_s;
  logic              ret_1_s, ret_2_s, alloc_1_s, alloc_2_s, fv_1_s, fv_2_s;
  logic [1:0]        ret_cnt_s;

  // Occupancy, allocation indices, in-order retire selection and next pointers.
  always_comb begin
    count_s     = tail_q - head_q;
    free_s      = DEPTH_P - {1'b0, count_s};
    alloc_ready = (free_s >= {{IDX_W{1'b0}}, 2'b10});
    rob_empty   = (count_s == PTR_ZERO);
    rob_idx_1   = tail_q[IDX_W-1:0];
    rob_idx_2   = tail_q[IDX_W-1:0] + IDX_ONE;
    alloc_1_s   = alloc_ready & alloc_valid_1;
    alloc_2_s   = alloc_1_s & alloc_valid_2;
    hidx_1_s    = head_q[IDX_W-1:0];
    hidx_2_s    = head_q[IDX_W-1:0] + IDX_ONE;
    ret_1_s     = valid_q[hidx_1_s] & done_q[hidx_1_s];
    ret_2_s     = ret_1_s & valid_q[hidx_2_s] & done_q[hidx_2_s];
    // p0 is architecturally pinned, so a write to it never releases its old mapping.
    fv_1_s      = ret_1_s & regwr_q[hidx_1_s] & (rd_q[hidx_1_s] != PREG_ZERO);
    fv_2_s      = ret_2_s & regwr_q[hidx_2_s] & (rd_q[hidx_2_s] != PREG_ZERO);
    ret_cnt_s   = {1'b0, ret_1_s} + {1'b0, ret_2_s};
    head_d      = head_q + {{(IDX_W-1){1'b0}}, ret_cnt_s};
    tail_d      = alloc_2_s ? (tail_q + PTR_TWO) : (alloc_1_s ? (tail_q + PTR_ONE) : tail_q);
  end

  // Entry state, pointers and registered retire/free outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q         <= {DEPTH{1'b0}};
      done_q          <= {DEPTH{1'b0}};
      regwr_q         <= {DEPTH{1'b0}};
      head_q          <= PTR_ZERO;
      tail_q          <= PTR_ZERO;
      freereg_valid_1 <= 1'b0;
      freereg_valid_2 <= 1'b0;
      freereg_1       <= PREG_ZERO;
      freereg_2       <= PREG_ZERO;
      retire_cnt      <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]  <= PREG_ZERO;
        old_q[i] <= PREG_ZERO;
      end
    end else if (flush) begin
      valid_q         <= {DEPTH{1'b0}};
      done_q          <= {DEPTH{1'b0}};
      head_q          <= PTR_ZERO;
      tail_q          <= PTR_ZERO;
      freereg_valid_1 <= 1'b0;
      freereg_valid_2 <= 1'b0;
      freereg_1       <= PREG_ZERO;
      freereg_2       <= PREG_ZERO;
      retire_cnt      <= 2'd0;
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      retire_cnt      <= ret_cnt_s;
      freereg_valid_1 <= fv_1_s;
      freereg_valid_2 <= fv_2_s;
      freereg_1       <= fv_1_s ? old_q[hidx_1_s] : PREG_ZERO;
      freereg_2       <= fv_2_s ? old_q[hidx_2_s] : PREG_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && ((cmpl_valid_a && (cmpl_idx_a == IDX_W'(i))) ||
                           (cmpl_valid_b && (cmpl_idx_b == IDX_W'(i))))) begin
          done_q[i] <= 1'b1;
        end
      end
      if (ret_1_s) begin
        valid_q[hidx_1_s] <= 1'b0;
        done_q[hidx_1_s]  <= 1'b0;
      end
      if (ret_2_s) begin
        valid_q[hidx_2_s] <= 1'b0;
        done_q[hidx_2_s]  <= 1'b0;
      end
      // Allocation slots never alias retiring head slots since two entries are always free.
      if (alloc_1_s) begin
        valid_q[rob_idx_1] <= 1'b1;
        done_q[rob_idx_1]  <= 1'b0;
        regwr_q[rob_idx_1] <= regwrite_1;
        rd_q[rob_idx_1]    <= rdout_1;
        old_q[rob_idx_1]   <= olddest_1;
      end
      if (alloc_2_s) begin
        valid_q[rob_idx_2] <= 1'b1;
        done_q[rob_idx_2]  <= 1'b0;
        regwr_q[rob_idx_2] <= regwrite_2;
        rd_q[rob_idx_2]    <= rdout_2;
        old_q[rob_idx_2]   <= olddest_2;
      end
    end
  end
endmodule
